// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes the immediate format of one
// instruction per cycle and presents it from a registered stage with a skid buffer.
module imm_gen_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam int unsigned OPW = 7;
  localparam int unsigned F3W = 3;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPW-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPW-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPW-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPW-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPW-1:0] OP_SYSTEM = 7'b1110011;

  logic [OPW-1:0] opcode;
  logic [F3W-1:0] funct3;
  entry_t         dec;

  entry_t m_q, m_d;
  entry_t k_q, k_d;
  logic   m_valid_q, m_valid_d;
  logic   k_valid_q, k_valid_d;

  logic accept;
  logic pop;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  // Combinational immediate decode of the incoming word
  always_comb begin
    dec         = '0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        dec.fmt = FMT_I;
        dec.imm = XLEN'($signed(in_instr[31:20]));
      end
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.fmt = FMT_SHAMT;
          dec.imm = XLEN'(in_instr[20 +: SHW]);
        end else begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(in_instr[31:20]));
        end
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end
      OP_SYSTEM: begin
        if (funct3[2]) begin
          dec.fmt = FMT_ZIMM;
          dec.imm = XLEN'(in_instr[19:15]);
        end else begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(in_instr[31:20]));
        end
      end
      default: begin
        dec.fmt     = FMT_NONE;
        dec.imm     = '0;
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Ready depends on skid occupancy only, so it never loops back through out_ready
  assign in_ready = rst_n && !k_valid_q;
  assign accept   = in_valid && in_ready;
  assign pop      = m_valid_q && out_ready;

  // Main/skid next-state: flush wins, then pop refills M from K, then accept
  always_comb begin
    m_d       = m_q;
    k_d       = k_q;
    m_valid_d = m_valid_q;
    k_valid_d = k_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else begin
      if (pop) begin
        if (k_valid_q) begin
          m_d       = k_q;
          m_valid_d = 1'b1;
          k_valid_d = 1'b0;
        end else begin
          m_valid_d = 1'b0;
        end
      end
      if (accept) begin
        if (!m_valid_q || (pop && !k_valid_q)) begin
          m_d       = dec;
          m_valid_d = 1'b1;
        end else begin
          k_d       = dec;
          k_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      k_q       <= '0;
      m_valid_q <= 1'b0;
      k_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      k_q       <= k_d;
      m_valid_q <= m_valid_d;
      k_valid_q <= k_valid_d;
    end
  end

  assign out_valid   = m_valid_q;
  assign out_imm     = m_q.imm;
  assign out_fmt     = 3'(m_q.fmt);
  assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance share
// the same stimulus; each step checks against hand-computed values.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;

  int checks   = 0;
  int failures = 0;

  imm_gen_pipe #(.XLEN(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32)
  );

  imm_gen_pipe #(.XLEN(64)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one word with out_ready=1 and check both widths one cycle later
  task automatic send_chk(input string tag, input logic [31:0] instr,
                          input logic [63:0] imm32, input logic [63:0] imm64,
                          input logic [2:0] fmt32, input logic [2:0] fmt64,
                          input logic ill);
    in_valid  = 1'b1;
    in_instr  = instr;
    out_ready = 1'b1;
    chk({tag, "_rdy"}, 64'(in_ready32), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_v32"},   64'(out_valid32),   64'd1);
    chk({tag, "_imm32"}, 64'(out_imm32),     imm32);
    chk({tag, "_fmt32"}, 64'(out_fmt32),     64'(fmt32));
    chk({tag, "_ill32"}, 64'(out_illegal32), 64'(ill));
    chk({tag, "_v64"},   64'(out_valid64),   64'd1);
    chk({tag, "_imm64"}, out_imm64,          imm64);
    chk({tag, "_fmt64"}, 64'(out_fmt64),     64'(fmt64));
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    out_ready = 1'b0;

    // Reset values
    #12;
    chk("rst_valid", 64'(out_valid32),   64'd0);
    chk("rst_imm",   64'(out_imm32),     64'd0);
    chk("rst_fmt",   64'(out_fmt32),     64'd0);
    chk("rst_ill",   64'(out_illegal32), 64'd0);
    chk("rst_rdy",   64'(in_ready32),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy_rise", 64'(in_ready32), 64'd1);
    @(negedge clk);

    // Single-word decodes
    send_chk("load",  32'hFFC12083, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 3'd1, 1'b0);
    send_chk("store", 32'h00512423, 64'h0000_0008, 64'h0000_0000_0000_0008, 3'd2, 3'd2, 1'b0);
    send_chk("br",    32'hFE000CE3, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 3'd3, 1'b0);
    send_chk("jal",   32'h0010006F, 64'h0000_0800, 64'h0000_0000_0000_0800, 3'd5, 3'd5, 1'b0);
    send_chk("srai3", 32'h4030D093, 64'd3,         64'd3,                   3'd6, 3'd6, 1'b0);
    send_chk("lui",   32'h123450B7, 64'h1234_5000, 64'h0000_0000_1234_5000, 3'd4, 3'd4, 1'b0);
    send_chk("illeg", 32'h0000007F, 64'd0,         64'd0,                   3'd0, 3'd0, 1'b1);
    send_chk("luineg",32'h800000B7, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 3'd4, 3'd4, 1'b0);
    send_chk("srai33",32'h4210D093, 64'd1,         64'd33,                  3'd6, 3'd6, 1'b0);
    send_chk("zimm",  32'h34015073, 64'd2,         64'd2,                   3'd7, 3'd7, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("drain_v", 64'(out_valid32), 64'd0);

    // Backpressure: A, B, C back-to-back with out_ready=0
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h123450B7;
    @(posedge clk); @(negedge clk);
    chk("bp_a_v",   64'(out_valid32), 64'd1);
    chk("bp_a_rdy", 64'(in_ready32),  64'd1);
    in_instr = 32'hFFC12083;
    @(posedge clk); @(negedge clk);
    chk("bp_b_rdy", 64'(in_ready32),  64'd0);
    chk("bp_hold1", 64'(out_imm32),   64'h1234_5000);
    in_instr = 32'h00512423;
    @(posedge clk); @(negedge clk);
    chk("bp_c_rdy", 64'(in_ready32),  64'd0);
    chk("bp_hold2", 64'(out_imm32),   64'h1234_5000);
    chk("bp_holdf", 64'(out_fmt32),   64'd4);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp_out_b",  64'(out_imm32),  64'hFFFF_FFFC);
    chk("bp_b_fmt",  64'(out_fmt32),  64'd1);
    chk("bp_rdy_up", 64'(in_ready32), 64'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("bp_out_c_v", 64'(out_valid32), 64'd1);
    chk("bp_out_c",   64'(out_imm32),   64'h0000_0008);
    chk("bp_c_fmt",   64'(out_fmt32),   64'd2);
    @(posedge clk); @(negedge clk);
    chk("bp_empty", 64'(out_valid32), 64'd0);

    // Flush with M and K full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0010006F;
    @(posedge clk); @(negedge clk);
    in_instr = 32'hFE000CE3;
    @(posedge clk); @(negedge clk);
    chk("fl_full", 64'(in_ready32), 64'd0);
    in_instr = 32'h4030D093;
    flush    = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("fl_v",   64'(out_valid32), 64'd0);
    chk("fl_rdy", 64'(in_ready32),  64'd1);
    // Flush in the same cycle as an accepted word
    in_instr = 32'h123450B7;
    @(posedge clk); @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    chk("fl_acc_v",   64'(out_valid32), 64'd0);
    chk("fl_acc_rdy", 64'(in_ready32),  64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("fl_quiet", 64'(out_valid32), 64'd0);
    end
    send_chk("fl_after", 32'h00512423, 64'h0000_0008, 64'h0000_0000_0000_0008, 3'd2, 3'd2, 1'b0);
    @(posedge clk); @(negedge clk);

    // Reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h123450B7;
    @(posedge clk); @(negedge clk);
    in_instr = 32'hFFC12083;
    @(posedge clk); @(negedge clk);
    chk("mr_pre_v", 64'(out_valid32), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_v",   64'(out_valid32),   64'd0);
    chk("mr_imm", 64'(out_imm32),     64'd0);
    chk("mr_fmt", 64'(out_fmt32),     64'd0);
    chk("mr_rdy", 64'(in_ready32),    64'd0);
    chk("mr_imm64", out_imm64,        64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("mr_rdy_up", 64'(in_ready32), 64'd1);
    chk("mr_v_post", 64'(out_valid32), 64'd0);
    @(negedge clk);
    send_chk("mr_restart", 32'hFE000CE3, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 3'd3, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("mr_end_v", 64'(out_valid32), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the decode stage. It accepts one 32-bit RISC-V instruction per cycle over a valid/ready handshake and classifies its immediate format (I, S, B, U, J, shift-amount, CSR zimm). It produces the XLEN-wide extended immediate from a registered output stage backed by a one-entry skid buffer. It sits between the fetch/instruction register and the ALU/branch operand muxes, and flags unsupported opcodes.

## Interface
- XLEN, 32, datapath width; legal values 32 and 64; sets immediate width and shamt width.
- SHW, $clog2(XLEN), derived shamt width (5 or 6); not overridden.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush; drops all buffered entries.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  block can accept in_instr this cycle.
- in_instr  in  32  instruction word.
- out_valid  out  1  out_* fields are valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
- out_illegal  out  1  opcode not in decode map.

## Operation
Decode is combinational on in_instr[6:0]. "sx" means sign-extend from in[31] to XLEN.
- 0000011 load, 1100111 jalr: fmt I, imm = sx(in[31:20]).
- 0010011 OP-IMM with funct3 001/101: fmt SHAMT, imm = zero-extended in[20+SHW-1:20].
- 0010011 OP-IMM with other funct3: fmt I, imm = sx(in[31:20]).
- 0100011 store: fmt S, imm = sx({in[31:25], in[11:7]}).
- 1100011 branch: fmt B, imm = sx({in[31], in[7], in[30:25], in[11:8], 1'b0}).
- 0110111 lui, 0010111 auipc: fmt U, imm = sx({in[31:12], 12'b0}). For XLEN=64, bits 63:32 copy in[31].
- 1101111 jal: fmt J, imm = sx({in[31], in[19:12], in[20], in[30:21], 1'b0}).
- 1110011 system with funct3[2]=1: fmt ZIMM, imm = zero-extended in[19:15].
- 1110011 system with funct3[2]=0: fmt I, imm = sx(in[31:20]).
- Any other opcode: fmt NONE, imm = 0, illegal = 1. In every other case illegal = 0.

Storage is a main register (M) that drives out_*, plus a skid register (K). Each has a valid bit.
- Accept condition: in_valid && in_ready.
- in_ready = rst_n && !K.valid. It depends only on state, never combinationally on out_ready.
- Pop condition: out_valid && out_ready.
- An accepted word loads into M if M is empty or a pop happens this cycle and K is empty. Otherwise it loads into K.
- On a pop with K valid: M <= K and K.valid <= 0. Any word accepted in the same cycle goes into K.
- Order is strictly FIFO. No entry is dropped or duplicated except on flush.
- flush has priority over everything: M.valid and K.valid clear, and any word accepted in the same cycle is discarded. Data registers may keep stale values.
- While out_valid && !out_ready, out_imm, out_fmt and out_illegal are held stable.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, K cleared, in_ready=0. in_ready is 1 in the first cycle after rst_n rises.
- Latency: an accept at edge N gives out_valid=1 with the decoded fields after edge N, i.e. one cycle.
- Throughput: one instruction per cycle while out_ready=1.
- Under backpressure, the block buffers two entries. in_ready falls the cycle after K fills and rises the cycle after K drains.
- Simultaneous accept, pop and K-empty: the word goes to M, and out_valid stays 1 with no bubble.
- Flush: out_valid=0 and in_ready=1 the cycle after the flush edge.
- Reset asserted mid-stream: all entries are lost immediately. There is no output glitch beyond the reset values.

## Test plan
- XLEN=32, single words with out_ready=1, each producing out_valid one cycle after accept:
  - 0xFFC12083 -> imm 0xFFFFFFFC, fmt 1.
  - 0x00512423 -> imm 0x00000008, fmt 2.
  - 0xFE000CE3 -> imm 0xFFFFFFF8, fmt 3.
  - 0x0010006F -> imm 0x00000800, fmt 5.
- XLEN=32 specials:
  - 0x4030D093 (srai x1,x1,3) -> imm 3, fmt 6.
  - 0x123450B7 -> imm 0x12345000, fmt 4.
  - 0x0000007F -> imm 0, fmt 0, illegal 1.
- XLEN=64: 0x800000B7 -> imm 0xFFFFFFFF80000000, fmt 4. srai with shamt 33 (0x4210D093) -> imm 33, fmt 6.
- Backpressure: out_ready=0, present A, B, C back-to-back.
  - A and B are accepted, and in_ready=0 while C waits.
  - After raising out_ready, A, B, C come out on consecutive cycles with no loss, reordering or duplication.
- Flush with M and K full, plus flush in the same cycle as an accept: the next cycle has out_valid=0 and in_ready=1, and none of the three words ever appear.
- Assert rst_n low for one cycle mid-stream: outputs go to the reset values at once, in_ready=0 during reset, and the stream restarts cleanly afterwards.
